// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: a 2-entry skid buffer (main M, skid S) with a registered in_ready.
// Define PIPE_STAGE_PERF_EN to add the saturating stall and flush performance counters.
module pipe_stage_reg #(
    parameter int                DATA_W      = 96,
    parameter int                CTRL_W      = 16,
    parameter int                ADDR_W      = 5,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}}
) (
    input  logic              clk_PIPE,
    input  logic              rst_n_PIPE,
    input  logic              flush_PIPE,
    input  logic              in_valid_PIPE,
    output logic              in_ready_PIPE,
    input  logic [DATA_W-1:0] in_data_PIPE,
    input  logic [CTRL_W-1:0] in_ctrl_PIPE,
    input  logic [ADDR_W-1:0] in_rd_PIPE,
    output logic              out_valid_PIPE,
    input  logic              out_ready_PIPE,
    output logic [DATA_W-1:0] out_data_PIPE,
    output logic [CTRL_W-1:0] out_ctrl_PIPE,
    output logic [ADDR_W-1:0] out_rd_PIPE
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       perf_stall_PIPE,
    output logic [15:0]       perf_flush_PIPE
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t              state_q, state_d;
    logic                ready_q;
    logic                in_xfer, out_xfer;
    logic                load_m_in, load_m_skid, load_s;
    logic [DATA_W-1:0]   m_data, s_data;
    logic [CTRL_W-1:0]   m_ctrl, s_ctrl;
    logic [ADDR_W-1:0]   m_rd, s_rd;

    // Ready comes from a flop; flush is the only combinational term, so no ready path crosses the stage.
    assign in_ready_PIPE  = ready_q & ~flush_PIPE;
    assign out_valid_PIPE = (state_q != EMPTY);
    assign in_xfer        = in_valid_PIPE & in_ready_PIPE;
    assign out_xfer       = out_valid_PIPE & out_ready_PIPE;

    assign out_data_PIPE  = m_data;
    assign out_ctrl_PIPE  = out_valid_PIPE ? m_ctrl : BUBBLE_CTRL;
    assign out_rd_PIPE    = out_valid_PIPE ? m_rd : {ADDR_W{1'b0}};

    always_ff @(posedge clk_PIPE or negedge rst_n_PIPE) begin
        if (!rst_n_PIPE) begin
            state_q <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != TWO);
        end
    end

    always_comb begin
        state_d     = state_q;
        load_m_in   = 1'b0;
        load_m_skid = 1'b0;
        load_s      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    load_m_in = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_m_in = 1'b1;
                end else if (in_xfer) begin
                    load_s  = 1'b1;
                    state_d = TWO;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    load_m_skid = 1'b1;
                    state_d     = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush_PIPE) begin
            state_d     = EMPTY;
            load_m_in   = 1'b0;
            load_m_skid = 1'b0;
            load_s      = 1'b0;
        end
    end

    always_ff @(posedge clk_PIPE or negedge rst_n_PIPE) begin
        if (!rst_n_PIPE) begin
            m_data <= {DATA_W{1'b0}};
            m_ctrl <= BUBBLE_CTRL;
            m_rd   <= {ADDR_W{1'b0}};
            s_data <= {DATA_W{1'b0}};
            s_ctrl <= BUBBLE_CTRL;
            s_rd   <= {ADDR_W{1'b0}};
        end else begin
            if (load_m_in) begin
                m_data <= in_data_PIPE;
                m_ctrl <= in_ctrl_PIPE;
                m_rd   <= in_rd_PIPE;
            end else if (load_m_skid) begin
                m_data <= s_data;
                m_ctrl <= s_ctrl;
                m_rd   <= s_rd;
            end
            if (load_s) begin
                s_data <= in_data_PIPE;
                s_ctrl <= in_ctrl_PIPE;
                s_rd   <= in_rd_PIPE;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // A flush only counts when it actually squashes something held in the stage.
    always_ff @(posedge clk_PIPE or negedge rst_n_PIPE) begin
        if (!rst_n_PIPE) begin
            perf_stall_PIPE <= 32'd0;
            perf_flush_PIPE <= 16'd0;
        end else begin
            if (out_valid_PIPE && !out_ready_PIPE)
                perf_stall_PIPE <= sat_inc32(perf_stall_PIPE);
            if (flush_PIPE && (state_q != EMPTY))
                perf_flush_PIPE <= sat_inc16(perf_flush_PIPE);
        end
    end
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised, elastic pipeline stage register that supersedes the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a generic data payload and a control payload between two pipeline stages using a valid/ready handshake.
- A 2-entry skid buffer keeps in_ready registered, so there is no combinational ready path through the stage.
- Supports synchronous flush, which inserts a bubble with a programmable NOP control value, for branch/jump squash.

Parameters:
DATA_W, 96, payload width (e.g. PC, rs1, rs2, imm packed by the instantiating stage)
CTRL_W, 16, control-field width (ALU op, branch, mem, writeback bits)
ADDR_W, 5, destination-register address width
BUBBLE_CTRL, {CTRL_W{1'b0}}, control value driven on reset, flush and empty (NOP)

Ports:
clk_PIPE  in  1  stage clock, rising edge
rst_n_PIPE  in  1  asynchronous active-low reset
flush_PIPE  in  1  synchronous squash of all held entries
in_valid_PIPE  in  1  upstream entry valid
in_ready_PIPE  out  1  stage can accept (registered, qualified by flush)
in_data_PIPE  in  DATA_W  upstream payload
in_ctrl_PIPE  in  CTRL_W  upstream control
in_rd_PIPE  in  ADDR_W  upstream destination register
out_valid_PIPE  out  1  downstream entry valid
out_ready_PIPE  in  1  downstream accepts
out_data_PIPE  out  DATA_W  payload to next stage
out_ctrl_PIPE  out  CTRL_W  control to next stage (BUBBLE_CTRL when not valid)
out_rd_PIPE  out  ADDR_W  destination register (0 when not valid)

Behaviour:
- Reset (async, rst_n_PIPE=0) forces the following immediately, independent of clock:
  - state = EMPTY, out_valid = 0, out_ctrl = BUBBLE_CTRL, out_rd = 0, out_data = 0.
  - Skid entry cleared; in_ready = 0 while in reset, 1 in the first cycle after release.
- Transfer rules:
  - Input transfer: in_valid & in_ready at the clock edge.
  - Output transfer: out_valid & out_ready at the clock edge.
- State machine (main register M, skid register S):
  - EMPTY: out_valid = 0. An input transfer loads M and moves to ONE.
  - ONE: out_valid = 1, outputs driven from M.
    - Input only: load S, move to TWO.
    - Output only: move to EMPTY.
    - Input and output in the same cycle: load M with the new entry, stay in ONE (full throughput).
  - TWO: in_ready = 0.
    - Output transfer: S moves to M, go to ONE.
    - Otherwise hold.
- in_ready = (state != TWO) & ~flush_PIPE. The registered full flag is ANDed with flush only.
- Latency: 1 cycle from input transfer to out_valid when the stage is EMPTY. Throughput is 1 entry per cycle when out_ready is held high.
- Ordering is strictly FIFO. No entry is ever duplicated or dropped, except on flush.
- Flush (sync): next state = EMPTY, both entries discarded, out_ctrl = BUBBLE_CTRL, out_rd = 0.
  - An input presented in the same cycle is NOT accepted (in_ready is already 0).
  - An output transfer in the flush cycle still completes downstream; the stage itself simply empties.
- Whenever out_valid = 0, out_ctrl = BUBBLE_CTRL and out_rd = 0. out_data holds its last value (don't-care).
- Stall: with out_ready = 0, M/S contents and all outputs are held stable. out_valid must not drop without a transfer, except on flush or reset.
- Reset asserted mid-transfer: all entries are lost and the stage returns to EMPTY. No partial update is allowed.

Optional Feature:
PIPE_STAGE_PERF_EN
- Defined: adds two output ports.
  - perf_stall_PIPE [31:0]: counts cycles with out_valid & ~out_ready.
  - perf_flush_PIPE [15:0]: counts flush cycles that discard at least one valid entry.
  - Both counters saturate at all-ones, reset to 0 on rst_n_PIPE, and are unaffected by flush.
- Not defined: ports and counters are absent. Functional behaviour is identical.

Test Plan:
- Reset release, idle inputs -> out_valid=0, out_ctrl=BUBBLE_CTRL, out_rd=0; in_ready=1 on the first post-reset cycle.
- Stream 8 entries (data 0x1..0x8, rd 1..8) with out_ready=1 -> each appears 1 cycle after input, in order; in_ready stays 1 throughout.
- out_ready=0 while sending 3 entries -> 2 accepted (state TWO), in_ready=0 on the 3rd. Raise out_ready -> entries 1 and 2 emerge in order, then the 3rd is accepted.
- In state TWO, pulse flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL. The flushed-cycle input is not seen at the output; the next input emerges normally.
- Assert rst_n_PIPE=0 mid-cycle while ONE -> outputs return to reset values before the next clock edge.
- With PIPE_STAGE_PERF_EN: 5 stall cycles plus 1 flush of a held entry -> perf_stall_PIPE=5, perf_flush_PIPE=1. A preloaded counter value of 0xFFFFFFFF stays saturated.
